// File: rtl/sys_ctrl_pkg.sv
// Shared state encoding and constants for the memory-to-UART sequencer.
package sys_ctrl_pkg;

    localparam int unsigned BYTES_PER_WORD     = 4;
    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned RD_TIMEOUT_DEFAULT = 15;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WB,
        TX_LOAD,
        TX_WAIT,
        DONE
    } seq_state_e;

endpackage

// File: rtl/mem_uart_sequencer.sv
// Reads a run of memory words, optionally writes back through the AES path,
// and streams each word LSB byte first to a UART transmitter.
module mem_uart_sequencer
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  MEM_DEPTH  = 64,
    parameter int unsigned  RD_TIMEOUT = RD_TIMEOUT_DEFAULT,
    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  encrypt_en,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_valid_out,
    output logic                  mux1_sel,
    output logic                  mux2_sel,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_data_valid,
    input  logic                  tx_busy,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_err
);

    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned BIDX_W = $clog2(BYTES_PER_WORD);
    localparam int unsigned TMR_W  = $clog2(RD_TIMEOUT + 1);

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      remain_q, remain_d;
    logic                  enc_q, enc_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [BIDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  hold_q, hold_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mux1_sel_q, mux1_sel_d;
    logic                  mux2_sel_q, mux2_sel_d;
    logic [BYTE_W-1:0]     tx_data_q, tx_data_d;
    logic                  tx_data_valid_q, tx_data_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_err_q, rd_err_d;
    logic [ADDR_WIDTH-1:0] addr_next;

    // Address advance wraps at MEM_DEPTH even when it is not a power of two.
    assign addr_next = (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

    // Next-state and next-output logic; outputs are set on entry to the state they belong to.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remain_d        = remain_q;
        enc_d           = enc_q;
        word_d          = word_q;
        byte_idx_d      = byte_idx_q;
        timer_d         = timer_q;
        hold_d          = hold_q;
        mem_addr_d      = mem_addr_q;
        tx_data_d       = tx_data_q;
        mem_rd_en_d     = 1'b0;
        mem_wr_en_d     = 1'b0;
        mux1_sel_d      = 1'b0;
        tx_data_valid_d = 1'b0;
        done_d          = 1'b0;
        rd_err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = base_addr;
                    remain_d   = word_count;
                    enc_d      = encrypt_en;
                    byte_idx_d = '0;
                    if (word_count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = RD_REQ;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = base_addr;
                    end
                end
            end
            RD_REQ: begin
                state_d = RD_WAIT;
                timer_d = '0;
            end
            RD_WAIT: begin
                if (mem_valid_out) begin
                    word_d  = mem_data_out;
                    timer_d = '0;
                    if (enc_q) begin
                        state_d     = WB;
                        mem_wr_en_d = 1'b1;
                        mux1_sel_d  = 1'b1;
                    end else begin
                        state_d = TX_LOAD;
                    end
                end else if (timer_q == TMR_W'(RD_TIMEOUT - 1)) begin
                    state_d  = IDLE;
                    rd_err_d = 1'b1;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WB: state_d = TX_LOAD;
            TX_LOAD: begin
                if (!tx_busy) begin
                    tx_data_d       = word_q[BYTE_W * 32'(byte_idx_q) +: BYTE_W];
                    tx_data_valid_d = 1'b1;
                    hold_d          = 1'b1;
                    state_d         = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // The UART needs a cycle to raise tx_busy after accepting a byte.
                if (hold_q) begin
                    hold_d = 1'b0;
                end else if (!tx_busy) begin
                    if (byte_idx_q != BIDX_W'(BYTES_PER_WORD - 1)) begin
                        byte_idx_d = byte_idx_q + BIDX_W'(1);
                        state_d    = TX_LOAD;
                    end else begin
                        byte_idx_d = '0;
                        remain_d   = remain_q - CNT_W'(1);
                        addr_d     = addr_next;
                        if (remain_q == CNT_W'(1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = RD_REQ;
                            mem_rd_en_d = 1'b1;
                            mem_addr_d  = addr_next;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        mux2_sel_d = (state_d != IDLE) && enc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remain_q        <= '0;
            enc_q           <= 1'b0;
            word_q          <= '0;
            byte_idx_q      <= '0;
            timer_q         <= '0;
            hold_q          <= 1'b0;
            mem_rd_en_q     <= 1'b0;
            mem_wr_en_q     <= 1'b0;
            mem_addr_q      <= '0;
            mux1_sel_q      <= 1'b0;
            mux2_sel_q      <= 1'b0;
            tx_data_q       <= '0;
            tx_data_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            rd_err_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remain_q        <= remain_d;
            enc_q           <= enc_d;
            word_q          <= word_d;
            byte_idx_q      <= byte_idx_d;
            timer_q         <= timer_d;
            hold_q          <= hold_d;
            mem_rd_en_q     <= mem_rd_en_d;
            mem_wr_en_q     <= mem_wr_en_d;
            mem_addr_q      <= mem_addr_d;
            mux1_sel_q      <= mux1_sel_d;
            mux2_sel_q      <= mux2_sel_d;
            tx_data_q       <= tx_data_d;
            tx_data_valid_q <= tx_data_valid_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            rd_err_q        <= rd_err_d;
        end
    end

    assign mem_rd_en     = mem_rd_en_q;
    assign mem_wr_en     = mem_wr_en_q;
    assign mem_addr      = mem_addr_q;
    assign mux1_sel      = mux1_sel_q;
    assign mux2_sel      = mux2_sel_q;
    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_data_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign rd_err        = rd_err_q;

endmodule

// File: tb/tb_mem_uart_sequencer.sv
// Self-checking bench for mem_uart_sequencer: vector table, directed corner cases
// and random transfers checked against a transaction-level model.
module tb_mem_uart_sequencer;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int TMO   = 15;

    logic          clk = 1'b0;
    logic          rst, start, encrypt_en;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_out = '0;
    logic          mem_valid_out = 1'b0;
    logic          mux1_sel, mux2_sel;
    logic [7:0]    tx_data;
    logic          tx_data_valid;
    logic          tx_busy = 1'b0;
    logic          busy, done, rd_err;

    mem_uart_sequencer #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .RD_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .encrypt_en(encrypt_en), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out), .mux1_sel(mux1_sel),
        .mux2_sel(mux2_sel), .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_busy(tx_busy),
        .busy(busy), .done(done), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [DW-1:0] mem [DEPTH];
    int         mem_lat = 1, blen = 0;
    bit         force_busy = 1'b0, cur_enc = 1'b0;
    int         cyc = 0, pend = 0, pend_addr = 0, busy_cnt = 0;
    int         rd_q[$], wr_q[$];
    logic [7:0] tx_q[$];
    int         n_done = 0, n_err = 0;
    int         last_rd_cyc = 0, last_wr_cyc = 0, last_err_cyc = 0, last_done_cyc = 0;
    int         first_tx_cyc = 0, start_cyc = 0;
    logic       p_rd = 0, p_wr = 0, p_tv = 0, p_done = 0, p_err = 0;

    typedef struct {
        int base; int count; bit enc; int lat; int blen; int exp_done; int exp_err;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor, memory responder and UART busy model, all evaluated mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (mem_rd_en) chk("rd_en_gap", 32'(p_rd), 0);
        if (mem_wr_en) chk("wr_en_gap", 32'(p_wr), 0);
        if (tx_data_valid) chk("tx_valid_gap", 32'(p_tv), 0);
        if (done) chk("done_gap", 32'(p_done), 0);
        if (rd_err) chk("rd_err_gap", 32'(p_err), 0);
        if (mem_rd_en) begin rd_q.push_back(int'(mem_addr)); last_rd_cyc = cyc; end
        if (mem_wr_en) begin
            wr_q.push_back(int'(mem_addr));
            last_wr_cyc = cyc;
            if (rd_q.size() > 0) chk("wr_addr", 32'(mem_addr), 32'(rd_q[$]));
        end
        chk("mux1_vs_wr", 32'(mux1_sel), 32'(mem_wr_en));
        chk("mux2_sel", 32'(mux2_sel), busy ? 32'(cur_enc) : 32'd0);
        if (tx_data_valid) begin
            tx_q.push_back(tx_data);
            if (tx_q.size() == 1) first_tx_cyc = cyc;
        end
        if (done) begin n_done++; last_done_cyc = cyc; end
        if (rd_err) begin n_err++; last_err_cyc = cyc; end
        p_rd = mem_rd_en; p_wr = mem_wr_en; p_tv = tx_data_valid; p_done = done; p_err = rd_err;

        mem_valid_out = 1'b0;
        if (rst) pend = 0;
        else begin
            if (pend != 0) begin
                pend--;
                if (pend == 0) begin mem_valid_out = 1'b1; mem_data_out = mem[pend_addr]; end
            end
            if (mem_rd_en) begin pend = mem_lat; pend_addr = int'(mem_addr); end
        end
        if (rst) busy_cnt = 0;
        else if (busy_cnt > 0) busy_cnt--;
        if (tx_data_valid && !rst) busy_cnt = blen;
        tx_busy = force_busy || (busy_cnt != 0);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input int b, input int c, input bit e);
        rd_q.delete(); wr_q.delete(); tx_q.delete();
        n_done = 0; n_err = 0; first_tx_cyc = 0;
        cur_enc = e; base_addr = AW'(b); word_count = (AW+1)'(c); encrypt_en = e;
        start = 1'b1; start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (!(busy == 1'b0 && (n_done + n_err) > 0) && k < 5000) begin tick(); k++; end
        chk({nm, "_hang"}, 32'(k >= 5000), 0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_rd_en"}, 32'(mem_rd_en), 0);
        chk({nm, "_wr_en"}, 32'(mem_wr_en), 0);
        chk({nm, "_addr"}, 32'(mem_addr), 0);
        chk({nm, "_mux1"}, 32'(mux1_sel), 0);
        chk({nm, "_mux2"}, 32'(mux2_sel), 0);
        chk({nm, "_tx_data"}, 32'(tx_data), 0);
        chk({nm, "_tx_valid"}, 32'(tx_data_valid), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_rd_err"}, 32'(rd_err), 0);
    endtask

    // Transaction-level expectation: which words are read, written back and sent.
    task automatic check_txn(input string nm, input int b, input int c, input bit e, input int lat);
        int er[$], ew[$];
        logic [7:0] eb[$];
        int ed, ee, a;
        if (c == 0) begin ed = 1; ee = 0; end
        else if (lat < 1 || lat > TMO) begin er.push_back(b); ed = 0; ee = 1; end
        else begin
            ed = 1; ee = 0;
            for (int w = 0; w < c; w++) begin
                a = (b + w) % DEPTH;
                er.push_back(a);
                if (e) ew.push_back(a);
                for (int by = 0; by < 4; by++) eb.push_back(8'(mem[a] >> (8 * by)));
            end
        end
        chk({nm, "_done"}, 32'(n_done), 32'(ed));
        chk({nm, "_err"}, 32'(n_err), 32'(ee));
        chk({nm, "_nreads"}, 32'(rd_q.size()), 32'(er.size()));
        for (int i = 0; i < er.size() && i < rd_q.size(); i++) chk({nm, "_rd_addr"}, 32'(rd_q[i]), 32'(er[i]));
        chk({nm, "_nwrites"}, 32'(wr_q.size()), 32'(ew.size()));
        for (int i = 0; i < ew.size() && i < wr_q.size(); i++) chk({nm, "_wr_addr"}, 32'(wr_q[i]), 32'(ew[i]));
        chk({nm, "_nbytes"}, 32'(tx_q.size()), 32'(eb.size()));
        for (int i = 0; i < eb.size() && i < tx_q.size(); i++) chk({nm, "_byte"}, 32'(tx_q[i]), 32'(eb[i]));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] plain_b [4];
        int         wrap_a [3];
        int         k, rel_cyc, b, c, lat;
        bit         e;

        plain_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        wrap_a  = '{63, 0, 1};
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[5] = 32'hA1B2C3D4;

        vecs[0] = '{5, 1, 1'b0, 1, 0, 1, 0};
        vecs[1] = '{63, 3, 1'b0, 2, 1, 1, 0};
        vecs[2] = '{10, 1, 1'b1, 3, 2, 1, 0};
        vecs[3] = '{0, 0, 1'b0, 1, 0, 1, 0};
        vecs[4] = '{7, 2, 1'b0, 0, 0, 0, 1};
        vecs[5] = '{20, 1, 1'b0, TMO, 0, 1, 0};
        vecs[6] = '{20, 1, 1'b0, TMO + 1, 0, 0, 1};
        vecs[7] = '{0, 64, 1'b0, 1, 0, 1, 0};
        vecs[8] = '{60, 5, 1'b1, 1, 3, 1, 0};

        // Reset with start held: must stay idle.
        rst = 1'b1; start = 1'b1; base_addr = '0; word_count = 7'd1; encrypt_en = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0; start = 1'b0;
        tick(); tick();
        chk("start_with_rst_busy", 32'(busy), 0);
        chk("start_with_rst_rd", 32'(rd_q.size()), 0);

        foreach (vecs[i]) begin
            mem_lat = vecs[i].lat; blen = vecs[i].blen;
            launch(vecs[i].base, vecs[i].count, vecs[i].enc);
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tbl_done", i), 32'(n_done), 32'(vecs[i].exp_done));
            chk($sformatf("vec%0d_tbl_err", i), 32'(n_err), 32'(vecs[i].exp_err));
            check_txn($sformatf("vec%0d", i), vecs[i].base, vecs[i].count, vecs[i].enc, vecs[i].lat);
            tick();
        end

        // Plain single word: literal byte order.
        mem_lat = 1; blen = 0;
        launch(5, 1, 1'b0);
        wait_idle("plain");
        chk("plain_nbytes", 32'(tx_q.size()), 4);
        for (int i = 0; i < 4 && i < tx_q.size(); i++) chk("plain_byte", 32'(tx_q[i]), 32'(plain_b[i]));
        chk("plain_nwr", 32'(wr_q.size()), 0);

        // Wrap at top of memory.
        mem_lat = 2; blen = 1;
        launch(63, 3, 1'b0);
        wait_idle("wrap");
        chk("wrap_nrd", 32'(rd_q.size()), 3);
        for (int i = 0; i < 3 && i < rd_q.size(); i++) chk("wrap_addr", 32'(rd_q[i]), 32'(wrap_a[i]));
        chk("wrap_nbytes", 32'(tx_q.size()), 12);

        // Encrypt: write-back one cycle after capture.
        mem_lat = 3; blen = 0;
        launch(10, 1, 1'b1);
        wait_idle("enc");
        chk("enc_wb_delay", 32'(last_wr_cyc - last_rd_cyc), 32'(mem_lat + 1));
        chk("enc_nwr", 32'(wr_q.size()), 1);

        // Read timeout timing.
        mem_lat = 0;
        launch(7, 1, 1'b0);
        wait_idle("tmo");
        chk("tmo_delay", 32'(last_err_cyc - last_rd_cyc), 32'(TMO + 1));
        chk("tmo_done", 32'(n_done), 0);
        chk("tmo_busy", 32'(busy), 0);

        // Zero-length transfer: done on the cycle after start.
        mem_lat = 1;
        launch(0, 0, 1'b1);
        chk("zero_done_now", 32'(done), 1);
        wait_idle("zero");
        chk("zero_done_delay", 32'(last_done_cyc - start_cyc), 1);
        check_txn("zero", 0, 0, 1'b1, 1);

        // Start while busy is ignored.
        mem_lat = 2; blen = 1;
        launch(30, 2, 1'b0);
        repeat (5) tick();
        start = 1'b1; base_addr = 6'd0; word_count = 7'd1; encrypt_en = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("ign");
        check_txn("ign", 30, 2, 1'b0, 2);
        repeat (5) tick();
        chk("ign_stays_idle", 32'(busy), 0);

        // tx_busy held for 100 cycles.
        force_busy = 1'b1; mem_lat = 2; blen = 0;
        launch(12, 1, 1'b0);
        repeat (100) tick();
        chk("txbusy_nbytes_held", 32'(tx_q.size()), 0);
        chk("txbusy_busy_held", 32'(busy), 1);
        force_busy = 1'b0; rel_cyc = cyc;
        wait_idle("txbusy");
        chk("txbusy_first_tx", 32'(first_tx_cyc), 32'(rel_cyc + 2));
        check_txn("txbusy", 12, 1, 1'b0, 2);

        // Reset during TX_WAIT of byte 2, then a clean transfer.
        mem_lat = 1; blen = 3;
        launch(40, 2, 1'b1);
        k = 0;
        while (tx_q.size() < 3 && k < 3000) begin tick(); k++; end
        chk("midrst_reach", 32'(k >= 3000), 0);
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        tick();
        chk("midrst_idle", 32'(busy), 0);
        blen = 0;
        launch(40, 2, 1'b1);
        wait_idle("after_rst");
        check_txn("after_rst", 40, 2, 1'b1, 1);

        // Random transfers.
        for (int t = 0; t < 25; t++) begin
            b = int'($urandom_range(0, DEPTH - 1));
            c = int'($urandom_range(0, 8));
            e = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) lat = ($urandom_range(0, 1) == 0) ? 0 : TMO + 1;
            else lat = int'($urandom_range(1, TMO));
            mem_lat = lat; blen = int'($urandom_range(0, 4));
            launch(b, c, e);
            wait_idle($sformatf("rnd%0d", t));
            check_txn($sformatf("rnd%0d", t), b, c, e, lat);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
